// File: rtl/alu_stress_bench_pkg.sv
// Shared definitions for the ALU stress harness: ALU opcodes, LFSR taps,
// FSM states and the bit layout of the LFSR-derived control word.
`default_nettype none

package alu_stress_bench_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int FLD_FUNCT3 = 0;
  localparam int FLD_ASHR   = 3;
  localparam int FLD_SUB    = 4;
  localparam int FLD_W      = 5;
  localparam int FLD_FWD1   = 6;
  localparam int FLD_FWD2   = 7;
  localparam int FLD_RD     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       ashr;
    logic       sub;
    logic       w;
  } alu_ctrl_t;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// Shared combinational ALU (RV-style ops); w selects 32-bit word forms on
// 64-bit builds, results sign-extended from bit 31.
`default_nettype none

module alu
  import alu_stress_bench_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sub,
  input  logic            ashr,
  input  logic [2:0]      funct3,
  input  logic            w,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] sum,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sll_x;
  logic [XLEN-1:0] srl_x;
  logic [XLEN-1:0] sra_x;
  logic [XLEN-1:0] add_w;
  logic [XLEN-1:0] sll_w;
  logic [XLEN-1:0] sr_w;

  assign shamt = op2[SHW-1:0];
  assign sum   = sub ? (op1 - op2) : (op1 + op2);
  assign eq    = (op1 == op2);
  assign lt    = ($signed(op1) < $signed(op2));
  assign ltu   = (op1 < op2);
  assign sll_x = op1 << shamt;
  assign srl_x = op1 >> shamt;
  assign sra_x = $signed(op1) >>> shamt;

  generate
    if (XLEN == 64) begin : g_word64
      logic [4:0]  sh5;
      logic [31:0] sll32;
      logic [31:0] srl32;
      logic [31:0] sra32;
      assign sh5   = op2[4:0];
      assign sll32 = op1[31:0] << sh5;
      assign srl32 = op1[31:0] >> sh5;
      assign sra32 = $signed(op1[31:0]) >>> sh5;
      assign add_w = {{32{sum[31]}}, sum[31:0]};
      assign sll_w = {{32{sll32[31]}}, sll32};
      assign sr_w  = ashr ? {{32{sra32[31]}}, sra32} : {{32{srl32[31]}}, srl32};
    end else begin : g_word32
      // At 32 bits the word forms coincide with the full-width ones.
      assign add_w = sum;
      assign sll_w = sll_x;
      assign sr_w  = ashr ? sra_x : srl_x;
    end
  endgenerate

  always_comb begin
    result = '0;
    case (funct3)
      F3_ADD:  result = w ? add_w : sum;
      F3_SLL:  result = w ? sll_w : sll_x;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      F3_XOR:  result = op1 ^ op2;
      F3_SR:   result = w ? sr_w : (ashr ? sra_x : srl_x);
      F3_OR:   result = op1 | op2;
      F3_AND:  result = op1 & op2;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_stress_bench_lfsr32.sv
// 32-bit Galois LFSR stimulus source with load-seed and enable; exposes the
// low OUT_W bits that form the control word.
`default_nettype none

module lfsr32
  import alu_stress_bench_pkg::*;
#(
  parameter logic [31:0] SEED  = 32'h1,
  parameter int          OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  output logic [OUT_W-1:0] value
);

  // An all-zero state would lock up the LFSR.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] state;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      state <= SEED_EFF;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

  assign value = state[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/alu_stress_bench.sv
// Self-driving ALU stress harness: LFSR issue -> forwarded operand registers
// -> alu -> register-file writeback and MISR signature.
`default_nettype none

module alu_stress_bench
  import alu_stress_bench_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 4,
  parameter int          NCYCLES = 1024,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] signature,
  output logic [23:0]     ops,
  output logic            tx
);

  localparam int          RW    = $clog2(NREGS);
  localparam int          LW    = FLD_RD + 3 * RW;
  localparam logic [24:0] N_LIM = 25'(NCYCLES);

  state_t          state;
  state_t          state_nx;
  logic            run_en;
  logic            start_go;
  logic            issue_done;

  logic [LW-1:0]   lfsr;
  alu_ctrl_t       ctrl_in;
  alu_ctrl_t       ctrl;
  alu_ctrl_t       ex;
  logic            fwd1;
  logic            fwd2;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd_p;
  logic            v0;
  logic            v1;
  logic [24:0]     count;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] sum;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic [XLEN-1:0] misr_in;

  lfsr32 #(
    .SEED  (SEED),
    .OUT_W (LW)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .en    (run_en),
    .load  (start_go),
    .value (lfsr)
  );

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .sub    (ex.sub),
    .ashr   (ex.ashr),
    .funct3 (ex.funct3),
    .w      (ex.w),
    .op1    (op1),
    .op2    (op2),
    .result (result),
    .sum    (sum),
    .eq     (eq),
    .lt     (lt),
    .ltu    (ltu)
  );

  always_comb begin
    ctrl_in        = '0;
    ctrl_in.funct3 = lfsr[FLD_FUNCT3 +: 3];
    ctrl_in.ashr   = lfsr[FLD_ASHR];
    ctrl_in.sub    = lfsr[FLD_SUB];
    ctrl_in.w      = (XLEN == 64) ? lfsr[FLD_W] : 1'b0;
  end

  // Flag outputs are folded in so synthesis must keep them.
  assign misr_in    = result ^ {{(XLEN-1){1'b0}}, (^sum) ^ eq ^ lt ^ ltu};
  assign issue_done = (count == N_LIM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    run_en   = (state == ST_RUN) && !halt;
    start_go = (state != ST_RUN) && start && !halt;
    state_nx = state;
    busy     = (state == ST_RUN);
    done     = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_go) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (run_en && issue_done && !v0 && v1) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || start_go) begin
      ctrl      <= '0;
      ex        <= '0;
      fwd1      <= 1'b0;
      fwd2      <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd_p      <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      count     <= '0;
      op1       <= '0;
      op2       <= '0;
      signature <= '0;
      ops       <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
      if (reset) tx <= 1'b0;
    end else if (run_en) begin
      if (!issue_done) begin
        ctrl  <= ctrl_in;
        fwd1  <= lfsr[FLD_FWD1];
        fwd2  <= lfsr[FLD_FWD2];
        rd    <= lfsr[FLD_RD +: RW];
        rs1   <= lfsr[FLD_RD + RW +: RW];
        rs2   <= lfsr[FLD_RD + 2 * RW +: RW];
        v0    <= 1'b1;
        count <= count + 25'd1;
      end else begin
        v0 <= 1'b0;
      end

      // The register-file read sees the value before this edge's writeback;
      // forwarding supplies the newer one.
      op1  <= fwd1 ? result : rf[rs1];
      op2  <= fwd2 ? result : rf[rs2];
      ex   <= ctrl;
      rd_p <= rd;
      v1   <= v0;

      if (v1) begin
        rf[rd_p]  <= result;
        signature <= {signature[XLEN-2:0], signature[XLEN-1]} ^ misr_in;
        ops       <= ops + 24'd1;
        tx        <= signature[XLEN-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_stress_bench.sv
// Bench for alu_stress_bench: run-level reference model of the LFSR/ALU/MISR
// flow, a vector table of halt patterns, and hand-written corner sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_stress_bench;

  localparam logic [31:0] SEED_B = 32'hACE1_2468;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        start_b = 1'b0;
  logic        halt_b = 1'b0;

  logic        a_busy, a_done, a_tx;
  logic [31:0] a_sig;
  logic [23:0] a_ops;
  logic        z_busy, z_done, z_tx;
  logic [31:0] z_sig;
  logic [23:0] z_ops;
  logic        b_busy, b_done, b_tx;
  logic [63:0] b_sig;
  logic [23:0] b_ops;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_stress_bench #(.XLEN(32), .NREGS(4), .NCYCLES(4), .SEED(32'h1)) u_a (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .busy(a_busy), .done(a_done), .signature(a_sig), .ops(a_ops), .tx(a_tx));

  alu_stress_bench #(.XLEN(32), .NREGS(4), .NCYCLES(4), .SEED(32'h0)) u_z (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .busy(z_busy), .done(z_done), .signature(z_sig), .ops(z_ops), .tx(z_tx));

  alu_stress_bench #(.XLEN(64), .NREGS(8), .NCYCLES(1024), .SEED(SEED_B)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .halt(halt_b),
    .busy(b_busy), .done(b_done), .signature(b_sig), .ops(b_ops), .tx(b_tx));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] alu_ref(input int xl, input logic [2:0] f3, input logic ashr,
                                          input logic sub, input logic w, input logic [63:0] a,
                                          input logic [63:0] b, output logic fold);
    logic [63:0] m, sum, r;
    longint sa, sb;
    logic eq, lt, ltu;
    int sh;
    m   = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sum = (sub ? a - b : a + b) & m;
    sa  = (xl == 64) ? longint'(a) : longint'(sext32(a[31:0]));
    sb  = (xl == 64) ? longint'(b) : longint'(sext32(b[31:0]));
    eq  = (a == b);
    lt  = (sa < sb);
    ltu = (a < b);
    sh  = (xl == 64) ? int'(b[5:0]) : int'(b[4:0]);
    case (f3)
      3'd0: r = w ? sext32(sum[31:0]) : sum;
      3'd1: r = w ? sext32(a[31:0] << b[4:0]) : ((a << sh) & m);
      3'd2: r = {63'b0, lt};
      3'd3: r = {63'b0, ltu};
      3'd4: r = a ^ b;
      3'd5: begin
        if (w) r = ashr ? sext32(32'($signed(a[31:0]) >>> b[4:0])) : sext32(a[31:0] >> b[4:0]);
        else   r = ashr ? (64'(sa >>> sh) & m) : (a >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    fold = (^sum) ^ eq ^ lt ^ ltu;
    return r;
  endfunction

  // Whole-run model: op i reads the register file as it stood before op i-1
  // wrote back, and forwarding delivers op i-1's result (0 before the first op).
  function automatic void model_run(input int xl, input int nregs, input int n,
                                    input logic [31:0] seed, output logic [63:0] sig,
                                    output logic tx);
    logic [63:0] rf [32];
    logic [63:0] prev_r, a, b, r;
    logic [31:0] s;
    logic        pend, fold, w;
    int rw, rd, rs1, rs2, pend_rd;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    s = (seed == 0) ? 32'h1 : seed;
    rw = $clog2(nregs);
    prev_r = '0; pend = 1'b0; pend_rd = 0; sig = '0; tx = 1'b0;
    for (int i = 0; i < n; i++) begin
      w   = (xl == 64) ? s[5] : 1'b0;
      rd  = int'((s >> 8) & 32'(nregs - 1));
      rs1 = int'((s >> (8 + rw)) & 32'(nregs - 1));
      rs2 = int'((s >> (8 + 2 * rw)) & 32'(nregs - 1));
      a = s[6] ? prev_r : rf[rs1];
      b = s[7] ? prev_r : rf[rs2];
      if (pend) rf[pend_rd] = prev_r;
      r = alu_ref(xl, s[2:0], s[3], s[4], w, a, b, fold);
      tx = sig[xl-1];
      if (xl == 64) sig = {sig[62:0], sig[63]};
      else          sig = {32'b0, sig[30:0], sig[31]};
      sig = sig ^ r ^ {63'b0, fold};
      prev_r = r; pend = 1'b1; pend_rd = rd;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
  endfunction

  typedef struct {
    int          halt_at;
    int          halt_len;
    int          exp_done;
    logic [63:0] exp_sig;
    logic        exp_tx;
  } vec_t;

  task automatic run_a(input vec_t v, input string tag);
    int done_edge;
    done_edge = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check($sformatf("%s busy_after_start", tag), a_busy, 1);
    for (int e = 1; e <= 40; e++) begin
      halt = (e > v.halt_at) && (e <= v.halt_at + v.halt_len);
      tick;
      if (a_done) begin
        done_edge = e;
        break;
      end
    end
    halt = 1'b0;
    check($sformatf("%s done_edge", tag), 64'(done_edge), 64'(v.exp_done));
    check($sformatf("%s ops", tag), a_ops, 4);
    check($sformatf("%s signature", tag), a_sig, v.exp_sig);
    check($sformatf("%s seed0_signature", tag), z_sig, v.exp_sig);
    check($sformatf("%s tx", tag), a_tx, v.exp_tx);
  endtask

  vec_t        tbl [8];
  logic [63:0] sig_a, sig_b;
  logic        tx_a, tx_b;

  initial begin
    int done_b, nh;
    vec_t clean;

    model_run(32, 4, 4, 32'h1, sig_a, tx_a);
    model_run(64, 8, 1024, SEED_B, sig_b, tx_b);

    tbl[0] = '{-1, 0, 6, sig_a, tx_a};
    tbl[1] = '{0, 3, 9, sig_a, tx_a};
    tbl[2] = '{2, 3, 9, sig_a, tx_a};
    tbl[3] = '{4, 3, 9, sig_a, tx_a};
    for (int i = 4; i < 8; i++) begin
      tbl[i].halt_at  = int'($urandom_range(0, 4));
      tbl[i].halt_len = int'($urandom_range(1, 4));
      tbl[i].exp_done = 6 + tbl[i].halt_len;
      tbl[i].exp_sig  = sig_a;
      tbl[i].exp_tx   = tx_a;
    end
    clean = tbl[0];

    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    repeat (10) tick;
    check("idle busy", a_busy, 0);
    check("idle done", a_done, 0);
    check("idle signature", a_sig, 0);
    check("idle ops", a_ops, 0);
    check("idle tx", a_tx, 0);
    check("idle b_signature", b_sig, 0);

    for (int i = 0; i < 8; i++) begin
      run_a(tbl[i], $sformatf("vec%0d", i));
    end

    // start while halted must not be taken
    halt = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    halt = 1'b0;
    tick;
    check("halted_start busy", a_busy, 0);
    check("halted_start done", a_done, 1);

    // reset two cycles into a run, then a clean rerun
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midreset busy", a_busy, 0);
    check("midreset done", a_done, 0);
    check("midreset signature", a_sig, 0);
    check("midreset ops", a_ops, 0);
    check("midreset tx", a_tx, 0);
    run_a(clean, "after_reset");

    // 64-bit long run with random halts and an ignored start in RUN
    done_b = -1;
    nh = 0;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    check("b busy_after_start", b_busy, 1);
    for (int e = 1; e <= 3000; e++) begin
      halt_b = (e != 200) && ($urandom_range(0, 9) == 0);
      start_b = (e == 200);
      if (halt_b) nh++;
      tick;
      start_b = 1'b0;
      if (b_done) begin
        done_b = e;
        break;
      end
    end
    halt_b = 1'b0;
    check("b done_edge", 64'(done_b), 64'(1026 + nh));
    check("b ops", b_ops, 1024);
    check("b signature", b_sig, sig_b);
    check("b tx", b_tx, tx_b);
    repeat (3) tick;
    check("b hold signature", b_sig, sig_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
